// File: rtl/add32_serial_pkg.sv
// Shared ALU definitions for the serial add/subtract unit: FSM state
// encodings, slice width and the add/sub opcodes the decoder maps onto 'sub'.
package add32_serial_pkg;

    localparam int SLICE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [3:0] ALU_OP_ADD = 4'b0000;
    localparam logic [3:0] ALU_OP_SUB = 4'b1000;

    // Decoder helper: subtract is the only opcode that asserts 'sub'.
    function automatic logic alu_op_is_sub(input logic [3:0] op);
        return (op == ALU_OP_SUB);
    endfunction

endpackage

// File: rtl/add32_serial_add8.sv
// 8-bit carry-lookahead slice: two 4-bit lookahead groups, with the upper
// group's carry-in formed from the lower group's generate/propagate.
module add8
    import add32_serial_pkg::*;
(
    input  logic [SLICE_W-1:0] a_i,
    input  logic [SLICE_W-1:0] b_i,
    input  logic               c_i,
    output logic [SLICE_W-1:0] s_o,
    output logic               c_o
);

    logic [SLICE_W-1:0] gen;
    logic [SLICE_W-1:0] prop;
    logic [SLICE_W:0]   carry;
    logic               grpGen;
    logic               grpProp;

    // Bit generate/propagate terms and the lower group's lookahead summary.
    always_comb begin
        gen     = a_i & b_i;
        prop    = a_i ^ b_i;
        grpGen  = gen[3]
                | (prop[3] & gen[2])
                | (prop[3] & prop[2] & gen[1])
                | (prop[3] & prop[2] & prop[1] & gen[0]);
        grpProp = &prop[3:0];
    end

    // Carries inside each group; the upper group starts from the lookahead carry.
    always_comb begin
        carry    = '0;
        carry[0] = c_i;
        for (int i = 0; i < 4; i++) begin
            carry[i+1] = gen[i] | (prop[i] & carry[i]);
        end
        carry[4] = grpGen | (grpProp & c_i);
        for (int i = 4; i < SLICE_W; i++) begin
            carry[i+1] = gen[i] | (prop[i] & carry[i]);
        end
    end

    assign s_o = prop ^ carry[SLICE_W-1:0];
    assign c_o = carry[SLICE_W];

endmodule

// File: rtl/add32_serial.sv
// Multi-cycle add/subtract unit: one 8-bit CLA slice is reused NSLICE times,
// with the inter-slice carry held in a register between edges.
module add32_serial
    import add32_serial_pkg::*;
#(
    parameter int NSLICE = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SLICE_W*NSLICE-1:0] a,
    input  logic [SLICE_W*NSLICE-1:0] b,
    input  logic                      sub,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SLICE_W*NSLICE-1:0] s,
    output logic                      cout,
    output logic                      ovf,
    output logic                      zero,
    output logic                      neg
);

    localparam int W     = SLICE_W * NSLICE;
    localparam int IDX_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    state_e             state_q;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic [W-1:0]       acc_q;
    logic [W-1:0]       acc_d;
    logic [W-1:0]       s_q;
    logic               carry_q;
    logic [IDX_W-1:0]   idx_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               cout_q;
    logic               ovf_q;
    logic               zero_q;
    logic               neg_q;

    logic [SLICE_W-1:0] aSlice;
    logic [SLICE_W-1:0] bSlice;
    logic [SLICE_W-1:0] sliceSum;
    logic               sliceCout;
    logic               lastSlice;

    // Route the byte selected by idx into the shared slice adder.
    always_comb begin
        aSlice = '0;
        bSlice = '0;
        for (int k = 0; k < NSLICE; k++) begin
            if (idx_q == IDX_W'(k)) begin
                aSlice = a_q[k*SLICE_W +: SLICE_W];
                bSlice = b_q[k*SLICE_W +: SLICE_W];
            end
        end
    end

    add8 u_add8 (
        .a_i (aSlice),
        .b_i (bSlice),
        .c_i (carry_q),
        .s_o (sliceSum),
        .c_o (sliceCout)
    );

    // Merge this edge's slice sum into the partial-result accumulator.
    always_comb begin
        acc_d = acc_q;
        for (int k = 0; k < NSLICE; k++) begin
            if (idx_q == IDX_W'(k)) begin
                acc_d[k*SLICE_W +: SLICE_W] = sliceSum;
            end
        end
    end

    assign lastSlice = (idx_q == IDX_W'(NSLICE - 1));

    // Handshake FSM; the visible result and flags load only on the last slice
    // so a partial sum never reaches the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            s_q         <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b ^ {W{sub}};
                        carry_q    <= sub;
                        idx_q      <= '0;
                        acc_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    acc_q   <= acc_d;
                    carry_q <= sliceCout;
                    idx_q   <= idx_q + IDX_W'(1);
                    if (lastSlice) begin
                        idx_q       <= '0;
                        s_q         <= acc_d;
                        cout_q      <= sliceCout;
                        neg_q       <= acc_d[W-1];
                        zero_q      <= (acc_d == '0);
                        ovf_q       <= (a_q[W-1] == b_q[W-1]) && (acc_d[W-1] != a_q[W-1]);
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign s         = s_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign neg       = neg_q;

endmodule

// File: doc/add32_serial.md
# add32_serial

Multi-cycle 32-bit add/subtract unit for the RISC-V ALU, built around one 8-bit CLA slice. It accepts an operand pair over a valid/ready handshake and drives one byte slice per clock through the slice adder. It carries the slice carry-out in a register and returns a 32-bit result plus condition flags over a second valid/ready handshake. It trades latency for area against a flat 32-bit CLA, sitting between the ALU operand muxes and the result writeback.

## Interface
- NSLICE, 4, number of 8-bit slices; datapath width W = 8*NSLICE.
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair present.
- in_ready  out  1  unit can accept; high only in IDLE.
- a  in  W  operand A.
- b  in  W  operand B.
- sub  in  1  0 = A+B, 1 = A−B (A + ~B + 1).
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer takes result.
- s  out  W  sum/difference.
- cout  out  1  carry out of MSB; for subtract, 1 = no borrow.
- ovf  out  1  signed overflow.
- zero  out  1  s == 0.
- neg  out  1  s[W-1].

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. If in_valid, then on the edge:
  - latch a_r=a and b_r = b ^ {W{sub}};
  - set carry_r=sub and idx=0;
  - go to RUN.
- RUN: the slice adder sees a_r[8*idx+:8], b_r[8*idx+:8] and c_1=carry_r. Each edge:
  - write s_r[8*idx+:8] from the sum;
  - set carry_r to the slice carry-out;
  - idx++.
  - On the edge processing idx=NSLICE-1, go to DONE.
- DONE: out_valid=1. All outputs hold stable until out_ready=1. On that edge go to IDLE.
- Flags are computed registered from the final state:
  - cout = carry_r;
  - neg = s_r[W-1];
  - zero = (s_r == 0);
  - ovf = (a_r[W-1] == b_r[W-1]) && (s_r[W-1] != a_r[W-1]), using the already-inverted b_r.
- All arithmetic is modulo 2^W. No saturation.
- in_valid is ignored outside IDLE. a/b/sub may change freely after the accept edge.
- Reset mid-operation abandons the operation. No partial result is ever presented.

## Timing
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0;
  - s=0, cout=ovf=zero=neg=0;
  - idx=0, carry_r=0.
- Latency: accept on edge E0 means slices are processed on edges E1..E_NSLICE, and out_valid is high after edge E_NSLICE. That is 4 edges at the default.
- Throughput: at most one operation per NSLICE+2 cycles. in_ready goes high the cycle after the output handshake. There is no overlap of input accept and output hold.
- out_ready held low keeps DONE indefinitely with s/flags frozen.
- Simulation clock period must be ≥1 ns: the slice adder's annotated delay chain is 0.6 ns (0.15+0.3+0.15), so the sum settles before the edge.
- rst dominates every other input on the same edge.

## Structure
- Shared ALU package/header holds:
  - state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the SLICE_W=8 constant;
  - the ALU add/sub opcode constants the decoder uses to drive sub.
- One sub-module: a single instance of the existing 8-bit CLA slice (add8). The slice select muxes, carry register, FSM and flag logic live in add32_serial.
- idx is a clog2(NSLICE)-bit counter.

## Test plan
- 0x0000_00FF + 0x0000_0001, sub=0 → s=0x0000_0100, cout=0, zero=0, ovf=0; out_valid exactly 4 edges after accept.
- 0xFFFF_FFFF + 0x0000_0001 → s=0x0000_0000, cout=1, zero=1, ovf=0, neg=0 (carry ripples across all slices).
- 0x7FFF_FFFF + 0x0000_0001 → s=0x8000_0000, ovf=1, neg=1, cout=0.
- Subtract cases:
  - 5 − 7 → s=0xFFFF_FFFE, cout=0, neg=1;
  - 7 − 5 → s=0x0000_0002, cout=1;
  - 0x8000_0000 − 1 → s=0x7FFF_FFFF, ovf=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid while toggling in_valid/a/b. Required response:
  - s and flags stay stable, in_ready=0, no new accept;
  - out_ready=1 for one cycle leads to IDLE on the next edge.
- Assert rst for one cycle while in RUN at idx=2. Required response:
  - next cycle shows IDLE, in_ready=1, out_valid=0, s=0;
  - a following 0x1234_5678 + 0x1111_1111 returns 0x2345_6789.
